// File: rtl/pma_if.sv
// Bundle of the configuration and lookup signals of the PMA region table.
// The table uses the slave modport; the agent that drives it uses master.
interface pma_if #(
    parameter int NrRegions = 8,
    parameter int AddrWidth = 64,
    parameter int NrPorts   = 2
);
    localparam int IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1;

    logic                         cfg_req_i;
    logic                         cfg_we_i;
    logic [IdxW-1:0]              cfg_idx_i;
    logic [1:0]                   cfg_field_i;
    logic [AddrWidth-1:0]         cfg_wdata_i;
    logic                         cfg_commit_i;
    logic                         cfg_rvalid_o;
    logic [AddrWidth-1:0]         cfg_rdata_o;
    logic                         cfg_err_o;
    logic [NrPorts-1:0]           lkp_valid_i;
    logic [NrPorts*AddrWidth-1:0] lkp_addr_i;
    logic [NrPorts-1:0]           rsp_valid_o;
    logic [NrPorts-1:0]           rsp_hit_o;
    logic [NrPorts*IdxW-1:0]      rsp_idx_o;
    logic [NrPorts-1:0]           rsp_exec_o;
    logic [NrPorts-1:0]           rsp_cached_o;
    logic [NrPorts-1:0]           rsp_nonidem_o;

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i, cfg_commit_i,
        input  lkp_valid_i, lkp_addr_i,
        output cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        output rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_exec_o, rsp_cached_o, rsp_nonidem_o
    );

    modport master (
        output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i, cfg_commit_i,
        output lkp_valid_i, lkp_addr_i,
        input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
        input  rsp_valid_o, rsp_hit_o, rsp_idx_o, rsp_exec_o, rsp_cached_o, rsp_nonidem_o
    );
endinterface

// File: rtl/pma_region_table.sv
// Runtime-programmable physical-memory-attribute table: shadow/active region copies with
// atomic commit, per-entry lock, and NrPorts independent single-cycle lookup channels.
module pma_region_table #(
    parameter int NrRegions = 8,
    parameter int AddrWidth = 64,
    parameter int NrPorts   = 2
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    pma_if.slave  bus
);
    localparam int IdxW = (NrRegions > 1) ? $clog2(NrRegions) : 1;
    localparam logic [IdxW:0] NrRegW = (IdxW + 1)'(NrRegions);

    typedef logic [AddrWidth-1:0] addr_t;

    addr_t      shd_base_q [NrRegions];
    addr_t      shd_len_q  [NrRegions];
    logic [4:0] shd_attr_q [NrRegions];
    addr_t      act_base_q [NrRegions];
    addr_t      act_len_q  [NrRegions];
    logic [4:0] act_attr_q [NrRegions];

    logic  cfg_rvalid_q, cfg_err_q;
    addr_t cfg_rdata_q;

    logic [NrPorts-1:0]      rsp_valid_q, rsp_hit_q, rsp_exec_q, rsp_cached_q, rsp_nonidem_q;
    logic [NrPorts*IdxW-1:0] rsp_idx_q;

    // Subtraction form keeps regions that end exactly at 2^AddrWidth from wrapping.
    function automatic logic region_match(addr_t a, addr_t base, addr_t len, logic vld);
        return vld && (len != '0) && (a >= base) && ((a - base) < len);
    endfunction

    logic  idx_oob, fld_bad, lock_hit, wr_ok, err_d, rd_req;
    addr_t cfg_rdata_d;

    always_comb begin
        idx_oob     = ({1'b0, bus.cfg_idx_i} >= NrRegW);
        fld_bad     = (bus.cfg_field_i == 2'd3);
        lock_hit    = 1'b0;
        cfg_rdata_d = '0;
        if (!idx_oob) begin
            lock_hit = act_attr_q[bus.cfg_idx_i][4];
            case (bus.cfg_field_i)
                2'd0:    cfg_rdata_d = shd_base_q[bus.cfg_idx_i];
                2'd1:    cfg_rdata_d = shd_len_q[bus.cfg_idx_i];
                2'd2:    cfg_rdata_d = addr_t'(shd_attr_q[bus.cfg_idx_i]);
                default: cfg_rdata_d = '0;
            endcase
        end
        rd_req = bus.cfg_req_i && !bus.cfg_we_i;
        wr_ok  = bus.cfg_req_i && bus.cfg_we_i && !idx_oob && !fld_bad && !lock_hit;
        err_d  = bus.cfg_req_i && (idx_oob || fld_bad || (bus.cfg_we_i && lock_hit));
    end

    logic [NrPorts-1:0]      hit_d, exec_d, cached_d, nonidem_d;
    logic [NrPorts*IdxW-1:0] idx_d;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_d     = '0;
        exec_d    = '0;
        cached_d  = '0;
        nonidem_d = '1;
        idx_d     = '0;
        for (int p = 0; p < NrPorts; p++) begin
            for (int i = NrRegions - 1; i >= 0; i--) begin
                if (region_match(bus.lkp_addr_i[p*AddrWidth +: AddrWidth],
                                 act_base_q[i], act_len_q[i], act_attr_q[i][0])) begin
                    hit_d[p]               = 1'b1;
                    idx_d[p*IdxW +: IdxW]  = IdxW'(i);
                    exec_d[p]              = act_attr_q[i][1];
                    cached_d[p]            = act_attr_q[i][2];
                    nonidem_d[p]           = act_attr_q[i][3];
                end
            end
        end
    end

    // Commit reads the pre-edge shadow, so a same-cycle write lands in shadow only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrRegions; i++) begin
                shd_base_q[i] <= '0;
                shd_len_q[i]  <= '0;
                shd_attr_q[i] <= '0;
                act_base_q[i] <= '0;
                act_len_q[i]  <= '0;
                act_attr_q[i] <= '0;
            end
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            if (wr_ok) begin
                case (bus.cfg_field_i)
                    2'd0:    shd_base_q[bus.cfg_idx_i] <= bus.cfg_wdata_i;
                    2'd1:    shd_len_q[bus.cfg_idx_i]  <= bus.cfg_wdata_i;
                    default: shd_attr_q[bus.cfg_idx_i] <= bus.cfg_wdata_i[4:0];
                endcase
            end
            if (bus.cfg_commit_i) begin
                for (int i = 0; i < NrRegions; i++) begin
                    act_base_q[i] <= shd_base_q[i];
                    act_len_q[i]  <= shd_len_q[i];
                    act_attr_q[i] <= shd_attr_q[i];
                end
            end
            cfg_rvalid_q <= rd_req;
            if (rd_req) cfg_rdata_q <= cfg_rdata_d;
            cfg_err_q <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q   <= '0;
            rsp_hit_q     <= '0;
            rsp_idx_q     <= '0;
            rsp_exec_q    <= '0;
            rsp_cached_q  <= '0;
            rsp_nonidem_q <= '1;
        end else begin
            rsp_valid_q <= bus.lkp_valid_i;
            for (int p = 0; p < NrPorts; p++) begin
                if (bus.lkp_valid_i[p]) begin
                    rsp_hit_q[p]              <= hit_d[p];
                    rsp_idx_q[p*IdxW +: IdxW] <= idx_d[p*IdxW +: IdxW];
                    rsp_exec_q[p]             <= exec_d[p];
                    rsp_cached_q[p]           <= cached_d[p];
                    rsp_nonidem_q[p]          <= nonidem_d[p];
                end
            end
        end
    end

    assign bus.cfg_rvalid_o  = cfg_rvalid_q;
    assign bus.cfg_rdata_o   = cfg_rdata_q;
    assign bus.cfg_err_o     = cfg_err_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_hit_o     = rsp_hit_q;
    assign bus.rsp_idx_o     = rsp_idx_q;
    assign bus.rsp_exec_o    = rsp_exec_q;
    assign bus.rsp_cached_o  = rsp_cached_q;
    assign bus.rsp_nonidem_o = rsp_nonidem_q;
endmodule

// File: tb/tb_pma_region_table.sv
// Directed bench for pma_region_table: programming, commit timing, priority, lock,
// address-space edge and error-path vectors with hand-computed expectations.
module tb_pma_region_table;
    localparam int NR = 8;
    localparam int AW = 64;
    localparam int NP = 2;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [63:0] rd_data;
    logic        rd_valid, rd_err, wr_err;

    pma_if #(.NrRegions(NR), .AddrWidth(AW), .NrPorts(NP)) bus ();

    pma_region_table #(.NrRegions(NR), .AddrWidth(AW), .NrPorts(NP)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [1:0] fld, input logic [63:0] d);
        bus.cfg_req_i   = 1'b1;
        bus.cfg_we_i    = 1'b1;
        bus.cfg_idx_i   = idx;
        bus.cfg_field_i = fld;
        bus.cfg_wdata_i = d;
        tick();
        wr_err          = bus.cfg_err_o;
        bus.cfg_req_i   = 1'b0;
        bus.cfg_we_i    = 1'b0;
    endtask

    task automatic rd(input logic [IW-1:0] idx, input logic [1:0] fld);
        bus.cfg_req_i   = 1'b1;
        bus.cfg_we_i    = 1'b0;
        bus.cfg_idx_i   = idx;
        bus.cfg_field_i = fld;
        tick();
        rd_data         = bus.cfg_rdata_o;
        rd_valid        = bus.cfg_rvalid_o;
        rd_err          = bus.cfg_err_o;
        bus.cfg_req_i   = 1'b0;
    endtask

    task automatic commit();
        bus.cfg_commit_i = 1'b1;
        tick();
        bus.cfg_commit_i = 1'b0;
    endtask

    task automatic lk(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1);
        bus.lkp_valid_i = v;
        bus.lkp_addr_i  = {a1, a0};
        tick();
        bus.lkp_valid_i = '0;
    endtask

    task automatic region(input logic [IW-1:0] idx, input logic [63:0] b,
                          input logic [63:0] l, input logic [63:0] a);
        wr(idx, 2'd0, b);
        wr(idx, 2'd1, l);
        wr(idx, 2'd2, a);
    endtask

    initial begin
        bus.cfg_req_i = 1'b0; bus.cfg_we_i = 1'b0; bus.cfg_idx_i = '0; bus.cfg_field_i = '0;
        bus.cfg_wdata_i = '0; bus.cfg_commit_i = 1'b0; bus.lkp_valid_i = '0; bus.lkp_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",   64'(bus.rsp_valid_o),   64'h0);
        check("rst_hit",     64'(bus.rsp_hit_o),     64'h0);
        check("rst_nonidem", 64'(bus.rsp_nonidem_o), 64'h3);
        check("rst_rvalid",  64'(bus.cfg_rvalid_o),  64'h0);
        check("rst_err",     64'(bus.cfg_err_o),     64'h0);
        @(negedge clk) rst_n = 1'b1;

        // T1: empty table misses conservatively
        lk(2'b01, 64'h8000_0000, 64'h0);
        check("t1_valid",   64'(bus.rsp_valid_o),      64'h1);
        check("t1_hit",     64'(bus.rsp_hit_o[0]),     64'h0);
        check("t1_nonidem", 64'(bus.rsp_nonidem_o[0]), 64'h1);
        check("t1_exec",    64'(bus.rsp_exec_o[0]),    64'h0);
        check("t1_cached",  64'(bus.rsp_cached_o[0]),  64'h0);

        // T2: single region, upper-edge hit then just-past miss
        region(3'd1, 64'h8000_0000, 64'h4000_0000, 64'h07);
        commit();
        lk(2'b01, 64'hBFFF_FFFF, 64'h0);
        check("t2_hit",     64'(bus.rsp_hit_o[0]),       64'h1);
        check("t2_idx",     64'(bus.rsp_idx_o[IW-1:0]),  64'h1);
        check("t2_exec",    64'(bus.rsp_exec_o[0]),      64'h1);
        check("t2_cached",  64'(bus.rsp_cached_o[0]),    64'h1);
        check("t2_nonidem", 64'(bus.rsp_nonidem_o[0]),   64'h0);
        tick();
        check("t2_idle_valid", 64'(bus.rsp_valid_o),     64'h0);
        check("t2_hold_hit",   64'(bus.rsp_hit_o[0]),    64'h1);
        lk(2'b01, 64'hC000_0000, 64'h0);
        check("t2_miss_hit",     64'(bus.rsp_hit_o[0]),      64'h0);
        check("t2_miss_idx",     64'(bus.rsp_idx_o[IW-1:0]), 64'h0);
        check("t2_miss_nonidem", 64'(bus.rsp_nonidem_o[0]),  64'h1);
        lk(2'b10, 64'h0, 64'h7FFF_FFFF);
        check("t2_below_hit", 64'(bus.rsp_hit_o[1]), 64'h0);

        // T3: overlapping regions, lowest index wins
        region(3'd0, 64'h8000_0000, 64'h1000, 64'h0B);
        commit();
        lk(2'b01, 64'h8000_0800, 64'h0);
        check("t3_idx",     64'(bus.rsp_idx_o[IW-1:0]), 64'h0);
        check("t3_hit",     64'(bus.rsp_hit_o[0]),      64'h1);
        check("t3_nonidem", 64'(bus.rsp_nonidem_o[0]),  64'h1);
        check("t3_cached",  64'(bus.rsp_cached_o[0]),   64'h0);
        lk(2'b10, 64'h0, 64'h8000_1000);
        check("t3_p1_idx",    64'(bus.rsp_idx_o[2*IW-1:IW]), 64'h1);
        check("t3_p1_cached", 64'(bus.rsp_cached_o[1]),      64'h1);
        rd(3'd0, 2'd2);
        check("t3_rd_attr",   rd_data,          64'h0B);
        check("t3_rd_rvalid", 64'(rd_valid),    64'h1);
        wr(3'd3, 2'd0, 64'h1234);
        rd(3'd3, 2'd0);
        check("t3_raw", rd_data, 64'h1234);
        wr(3'd3, 2'd2, 64'hFFE0);
        rd(3'd3, 2'd2);
        check("t3_attr_upper", rd_data, 64'h0);

        // T4: commit timing with back-to-back lookups on both ports
        wr(3'd0, 2'd2, 64'h05);
        lk(2'b11, 64'h8000_0800, 64'h8000_0100);
        check("t4_pre_exec", 64'(bus.rsp_exec_o), 64'h3);
        bus.cfg_commit_i = 1'b1;
        lk(2'b11, 64'h8000_0800, 64'h8000_0100);
        bus.cfg_commit_i = 1'b0;
        check("t4_cc_exec",    64'(bus.rsp_exec_o),    64'h3);
        check("t4_cc_cached",  64'(bus.rsp_cached_o),  64'h0);
        check("t4_cc_nonidem", 64'(bus.rsp_nonidem_o), 64'h3);
        lk(2'b11, 64'h8000_0800, 64'h8000_0100);
        check("t4_new_exec",    64'(bus.rsp_exec_o),    64'h0);
        check("t4_new_cached",  64'(bus.rsp_cached_o),  64'h3);
        check("t4_new_nonidem", 64'(bus.rsp_nonidem_o), 64'h0);
        check("t4_new_valid",   64'(bus.rsp_valid_o),   64'h3);
        // write and commit in the same cycle
        bus.cfg_commit_i = 1'b1;
        wr(3'd0, 2'd2, 64'h0B);
        bus.cfg_commit_i = 1'b0;
        lk(2'b01, 64'h8000_0800, 64'h0);
        check("t4_wc_cached", 64'(bus.rsp_cached_o[0]), 64'h1);
        rd(3'd0, 2'd2);
        check("t4_wc_shadow", rd_data, 64'h0B);
        commit();
        lk(2'b01, 64'h8000_0800, 64'h0);
        check("t4_wc_after", 64'(bus.rsp_nonidem_o[0]), 64'h1);

        // T5: lock, then reset clears it
        region(3'd2, 64'h1000_0000, 64'h100, 64'h13);
        check("t5_wr_ok_err", 64'(wr_err), 64'h0);
        commit();
        wr(3'd2, 2'd0, 64'h2000);
        check("t5_lock_err", 64'(wr_err), 64'h1);
        rd(3'd2, 2'd0);
        check("t5_lock_shadow", rd_data,      64'h1000_0000);
        check("t5_err_clear",   64'(rd_err),  64'h0);
        lk(2'b10, 64'h0, 64'h1000_0010);
        check("t5_lk_idx",  64'(bus.rsp_idx_o[2*IW-1:IW]), 64'h2);
        check("t5_lk_exec", 64'(bus.rsp_exec_o[1]),        64'h1);
        rst_n = 1'b0;
        #1;
        check("t5_async_valid",   64'(bus.rsp_valid_o),   64'h0);
        check("t5_async_hit",     64'(bus.rsp_hit_o),     64'h0);
        check("t5_async_nonidem", 64'(bus.rsp_nonidem_o), 64'h3);
        tick();
        @(negedge clk) rst_n = 1'b1;
        wr(3'd2, 2'd0, 64'h2000);
        check("t5_unlock_err", 64'(wr_err), 64'h0);
        rd(3'd2, 2'd0);
        check("t5_unlock_rd", rd_data, 64'h2000);

        // T6: region at the very top of the address space, reserved field read
        region(3'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 64'h01);
        commit();
        lk(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        check("t6_top_hit",     64'(bus.rsp_hit_o[0]),     64'h1);
        check("t6_top_nonidem", 64'(bus.rsp_nonidem_o[0]), 64'h0);
        lk(2'b01, 64'h0, 64'h0);
        check("t6_zero_hit", 64'(bus.rsp_hit_o[0]), 64'h0);
        rd(3'd0, 2'd3);
        check("t6_f3_rvalid", 64'(rd_valid), 64'h1);
        check("t6_f3_rdata",  rd_data,       64'h0);
        check("t6_f3_err",    64'(rd_err),   64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
